// File: rtl/fetch_inst_queue.sv
// Instruction queue: compacts masked 4-word fetch groups into a ring, presents two entries to ID.
// Latency: write visible next cycle, read consumed in zero cycles; optional IQ_PERF_CNT_EN counters.
// Backpressure: ID_stopFetch_o asserts while free entries < STOP_FREE; overflowing groups are dropped whole.
module fetch_inst_queue #(
   parameter int DEPTH     = 16,
   parameter int STOP_FREE = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inst_data_ok,
   input  logic [127:0]             inst_rdata,
   input  logic [31:0]              PCR_VAddr_i,
   input  logic [3:0]               PCR_instEnable_i,
   input  logic                     PCR_hasException_i,
   input  logic [4:0]               PCR_ExcCode_i,
   input  logic                     IQ_flush_i,
   input  logic [1:0]               ID_readNum_i,
   output logic                     IQ_valid0_o,
   output logic                     IQ_valid1_o,
   output logic [31:0]              IQ_inst0_o,
   output logic [31:0]              IQ_inst1_o,
   output logic [31:0]              IQ_pc0_o,
   output logic [31:0]              IQ_pc1_o,
   output logic                     IQ_hasExc0_o,
   output logic                     IQ_hasExc1_o,
   output logic [4:0]               IQ_excCode0_o,
   output logic [4:0]               IQ_excCode1_o,
   output logic [$clog2(DEPTH):0]   IQ_count_o,
   output logic                     ID_stopFetch_o
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        has_exc;
      logic [4:0]  exc_code;
   } iq_entry_t;

   iq_entry_t     mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d, free_w, wr_num;
   logic [2:0]    pfx [5];
   logic [3:0]    wr_en;
   logic [AW-1:0] wr_idx [4];
   iq_entry_t     wr_ent [4];
   logic          ovf, wr_ok;
   iq_entry_t     ent0, ent1;

   always_comb begin
      pfx[0] = 3'd0;
      for (int i = 0; i < 4; i++) begin
         pfx[i+1] = pfx[i] + {2'b00, PCR_instEnable_i[i]};
      end
      free_w = (AW+1)'(DEPTH) - count_q;
      wr_num = '0;
      if (inst_data_ok) begin
         wr_num = PCR_hasException_i ? (AW+1)'(1) : (AW+1)'(pfx[4]);
      end
      ovf   = wr_num > free_w;
      wr_ok = !ovf && !IQ_flush_i;

      // Word i lands at tail plus the number of enabled words below it.
      for (int i = 0; i < 4; i++) begin
         wr_idx[i] = tail_q + AW'(pfx[i]);
         wr_ent[i] = '{inst: inst_rdata[32*i +: 32],
                       pc: {PCR_VAddr_i[31:4], 2'(i), 2'b00},
                       has_exc: 1'b0, exc_code: 5'd0};
         wr_en[i]  = inst_data_ok && !PCR_hasException_i && PCR_instEnable_i[i] && wr_ok;
      end
      if (inst_data_ok && PCR_hasException_i) begin
         wr_idx[0] = tail_q;
         wr_ent[0] = '{inst: 32'h0, pc: PCR_VAddr_i, has_exc: 1'b1, exc_code: PCR_ExcCode_i};
         wr_en[0]  = wr_ok;
      end

      if (IQ_flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + AW'(ID_readNum_i);
         tail_d  = tail_q + (wr_ok ? wr_num[AW-1:0] : '0);
         count_d = count_q + (wr_ok ? wr_num : '0) - (AW+1)'(ID_readNum_i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) mem_q[wr_idx[i]] <= wr_ent[i];
      end
   end

   assign ent0           = mem_q[head_q];
   assign ent1           = mem_q[head_q + AW'(1)];
   assign IQ_valid0_o    = count_q > (AW+1)'(0);
   assign IQ_valid1_o    = count_q > (AW+1)'(1);
   assign IQ_inst0_o     = ent0.inst;
   assign IQ_inst1_o     = ent1.inst;
   assign IQ_pc0_o       = ent0.pc;
   assign IQ_pc1_o       = ent1.pc;
   assign IQ_hasExc0_o   = ent0.has_exc;
   assign IQ_hasExc1_o   = ent1.has_exc;
   assign IQ_excCode0_o  = ent0.exc_code;
   assign IQ_excCode1_o  = ent1.exc_code;
   assign IQ_count_o     = count_q;
   assign ID_stopFetch_o = free_w < (AW+1)'(STOP_FREE);

`ifdef IQ_PERF_CNT_EN
   logic [31:0] stallCycles_q, dropGroups_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCycles_q <= '0;
         dropGroups_q  <= '0;
      end else begin
         if (ID_stopFetch_o) stallCycles_q <= stallCycles_q + 32'd1;
         if (inst_data_ok && ovf && !IQ_flush_i) dropGroups_q <= dropGroups_q + 32'd1;
      end
   end
`else
`endif
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Instruction queue between the I-Cache read port and decode. Each cycle it accepts one 4-word fetch group plus its per-word enable mask from the PC stage. It compacts the enabled words into a circular buffer and presents up to two instructions per cycle to ID. It raises `ID_stopFetch_o` to hold off the PC stage before space runs out, and is cleared completely by any pipeline flush.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥ 8.
- `STOP_FREE`, 8: `ID_stopFetch_o` asserts while free entries < `STOP_FREE`. This covers the group being written plus one group still in flight.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `inst_data_ok` input 1: fetch group valid this cycle.
- `inst_rdata` input 128: word i at [32i+31:32i].
- `PCR_VAddr_i` input 32: group VAddr; bits [31:4] form the group base.
- `PCR_instEnable_i` input 4: bit i set means word i is wanted.
- `PCR_hasException_i` input 1: fetch address error on this group.
- `PCR_ExcCode_i` input 5: exception code for this group.
- `IQ_flush_i` input 1: clear queue (exception, back-end or front-end mispredict).
- `ID_readNum_i` input 2: entries ID consumes this cycle, 0..2; must not exceed the valid outputs.
- `IQ_valid0_o`, `IQ_valid1_o` output 1 each: head and head+1 hold data.
- `IQ_inst0_o`, `IQ_inst1_o` output 32 each: instruction words.
- `IQ_pc0_o`, `IQ_pc1_o` output 32 each: instruction PCs.
- `IQ_hasExc0_o`, `IQ_hasExc1_o` output 1 each: entry carries a fetch exception.
- `IQ_excCode0_o`, `IQ_excCode1_o` output 5 each: exception code.
- `IQ_count_o` output log2(DEPTH)+1: occupied entries.
- `ID_stopFetch_o` output 1: back-pressure to the PC stage.

## Operation
- **Entry contents:** {inst[31:0], pc[31:0], hasExc, excCode[4:0]}.
- **State:** head pointer, tail pointer (log2(DEPTH) bits each, wrap modulo DEPTH) and count.
- **Normal write** (`inst_data_ok` and not exception):
  - n = popcount(`PCR_instEnable_i`).
  - Enabled words are written in ascending word order to tail, tail+1, …, tail+n-1.
  - Word i gets pc = {VAddr[31:4], i[1:0], 2'b00}.
  - The mask may be non-contiguous (e.g. 4'b0101); compaction uses a prefix count of the mask.
- **Exception write** (`inst_data_ok` and `PCR_hasException_i`):
  - Exactly one entry is written: inst = 32'h0, pc = `PCR_VAddr_i` (unaligned, unmodified), hasExc = 1, excCode = `PCR_ExcCode_i`.
  - The mask is ignored.
- **Read:**
  - Outputs combinationally show entries head and head+1.
  - `IQ_validk_o` = count > k.
  - head advances by `ID_readNum_i`.
- **Count:** next count = count + written − read; reading and writing in the same cycle is legal.
- **Overflow:** a write whose n exceeds free entries is dropped whole; no entry or pointer changes from it. Under correct `ID_stopFetch_o` use this never occurs.
- **Flush:** `IQ_flush_i` sets head = tail = count = 0. It has priority over a simultaneous write and read; the same-cycle group is discarded.
- **Back-pressure:** `ID_stopFetch_o` = (DEPTH − count) < `STOP_FREE`. It is combinational from the count register.

## Timing
- **Reset values:** count, head, tail = 0; all `IQ_valid*_o` = 0; `ID_stopFetch_o` = 0; data outputs show entry 0/1 contents (don't-care while invalid). Entry storage is not reset.
- **Write latency:** a write in cycle T is visible at the outputs in T+1. There is no same-cycle bypass.
- **Read latency:** a read in cycle T updates the outputs in T+1. Zero-cycle consume as seen by ID.
- **Stop timing:** `ID_stopFetch_o` reflects the count registered at the previous edge. The `STOP_FREE` margin absorbs one more accepted group.
- **Wrap-around:** writes and reads spanning index DEPTH−1 → 0 stay in order.
- **Reset mid-operation:** asserting `rst` immediately empties the queue, regardless of the clock.

## Configuration
- **`IQ_PERF_CNT_EN` defined:** adds two free-running 32-bit counters, reset to 0 by `rst`, visible internally for simulation and debug.
  - `stallCycles`: increments each cycle `ID_stopFetch_o` = 1.
  - `dropGroups`: increments on each overflow-dropped write.
- **`IQ_PERF_CNT_EN` undefined:** neither counter exists; functional behaviour is identical.

## Test plan
- **Basic write/read:** reset, then write a group with mask 4'b1111, VAddr 32'hBFC0_0000, words A,B,C,D.
  - Next cycle: valid0/1 = 1, pc0 = BFC0_0000, pc1 = BFC0_0004, count = 4.
  - Read 2 twice → count 0, valids 0.
- **Compaction:** write mask 4'b0101, VAddr 32'h8000_0010 → two entries, pc 8000_0010 and 8000_0018, count = 2.
- **Exception write:** VAddr 32'hBFC0_0002 with hasException and ExcCode 5'h04 → one entry, hasExc0 = 1, pc0 = BFC0_0002, inst0 = 0.
- **Back-pressure, wrap and overflow:**
  - Fill with four full groups, no reads → count 16, stopFetch = 1 from count 9 onward.
  - Read 2 per cycle until head wraps; PCs must stay in order.
  - Write with count 14 and mask 4'b1111 → dropped, count unchanged.
- **Flush priority:** at count 6, assert flush with a write and readNum = 2 in the same cycle → next cycle count 0, valids 0, stopFetch 0.
- **Async reset:** assert `rst` low between clock edges at count 5 → count and valids read 0 before the next edge.
